regfile_wr_arbiter: RTL and testbench
=====================================

// Module: regfile_wr_arbiter
// PURPOSE
//  Shares the single register-file write port between core writeback (A) and the multi-cycle
//  mult/div result path (B). Fixed priority to A, starvation guard for B, registered write port.
//  Holds a 32-entry pending-write scoreboard so decode can stall on reads of claimed registers.
// PARAMETERS
//  DATA_W        32  write data width
//  ADDR_W        5   register address width (2**ADDR_W registers)
//  STARVE_LIMIT  4   consecutive stalled B cycles before B is forced ahead of A (>=1)
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst_n        in   1       synchronous reset, active-low
//  a_valid      in   1       A write request
//  a_ready      out  1       A request accepted this cycle when a_valid&a_ready
//  a_addr       in   ADDR_W  A destination register
//  a_data       in   DATA_W  A write data
//  b_valid      in   1       B write request
//  b_ready      out  1       B request accepted this cycle when b_valid&b_ready
//  b_addr       in   ADDR_W  B destination register
//  b_data       in   DATA_W  B write data
//  claim_valid  in   1       B op issued; mark claim_addr pending
//  claim_addr   in   ADDR_W  register claimed by B
//  raddr1       in   ADDR_W  decode read address 1
//  raddr2       in   ADDR_W  decode read address 2
//  hazard1      out  1       pend[raddr1], combinational
//  hazard2      out  1       pend[raddr2], combinational
//  rf_we        out  1       register-file write enable (registered)
//  rf_waddr     out  ADDR_W  register-file write address (registered)
//  rf_wdata     out  DATA_W  register-file write data (registered)
//  claim_err    out  1       1-cycle pulse: claim of an already-pending register
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): pend=0, starve_cnt=0, rf_we=0, rf_waddr=0, rf_wdata=0, claim_err=0.
//    Reset mid-operation discards all pending claims and any in-flight grant; no write issued.
//  - force_b = (starve_cnt >= STARVE_LIMIT). Grant (combinational):
//    a_ready = ~(force_b & b_valid);  b_ready = ~a_valid | force_b.
//    Exactly one of A/B accepted when both valid; neither ready depends on its own valid.
//  - starve_cnt: B accepted or ~b_valid -> 0; b_valid & ~b_ready -> +1, saturating.
//  - Write port, latency 1: accepted request at edge N drives rf_we/rf_waddr/rf_wdata during
//    cycle N+1 (regfile commits on following falling edge). rf_we = accepted & (addr != 0);
//    addr 0 requests are accepted and dropped. No accept -> rf_we=0, addr/data hold last value.
//  - Scoreboard pend[2**ADDR_W-1:0], bit 0 always 0:
//    claim_valid & claim_addr!=0 -> set pend[claim_addr]; B accepted -> clear pend[b_addr].
//    Simultaneous set and clear of same bit: set wins (new op supersedes).
//    claim of bit already 1 (and not cleared same cycle) -> claim_err=1 next cycle; bit stays 1.
//    A writes never touch pend (B result later overwrites, preserving program order).
//  - hazard1/2 read pend directly; a register stops hazarding the cycle after its B accept,
//    the same cycle rf_we carries its data.
// TESTING
//  1 Reset: rst_n=0 2 cycles with all valids high -> rf_we=0, hazards 0, claim_err 0 after.
//  2 A only: a_valid, a_addr=5, a_data=0xDEADBEEF -> a_ready=1; next cycle rf_we=1,
//    rf_waddr=5, rf_wdata=0xDEADBEEF.
//  3 Starvation: a_valid and b_valid held, STARVE_LIMIT=4 -> A wins 4 cycles, 5th cycle
//    b_ready=1,a_ready=0, B written next cycle; counter back to 0, A resumes.
//  4 Scoreboard: claim r9; raddr1=9 -> hazard1=1 until B writes r9 (addr 9, 0x1234) accepted;
//    next cycle hazard1=0, rf_we=1, rf_waddr=9, rf_wdata=0x1234.
//  5 Edges: claim r9 twice -> claim_err pulse once; claim r0 -> pend unchanged;
//    A write to r0 -> a_ready=1, rf_we stays 0; claim r7 same cycle as B accept r7 -> pend[7]=1.
//  6 Reset mid-op: pend r3 set, B accepted at edge N, rst_n=0 at edge N+1 -> rf_we=0, hazards 0.

Source files
------------

// File: rtl/regfile_wr_arbiter_if.sv
// Register-file write-port bundle: A/B write requests, B claim, decode read ports, write port.
// Requesters and decode sit on the master side; the arbiter is the slave.
interface regfile_wr_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
);
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              claim_valid;
    logic [ADDR_W-1:0] claim_addr;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              hazard1;
    logic              hazard2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              claim_err;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               claim_valid, claim_addr, raddr1, raddr2,
        input  a_ready, b_ready, hazard1, hazard2, rf_we, rf_waddr, rf_wdata, claim_err
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
               claim_valid, claim_addr, raddr1, raddr2,
        output a_ready, b_ready, hazard1, hazard2, rf_we, rf_waddr, rf_wdata, claim_err
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between writeback (A, priority) and mult/div (B),
// with a starvation guard for B and a pending-write scoreboard for decode hazards.
module regfile_wr_arbiter #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    regfile_wr_arbiter_if.slave  bus
);
    localparam int unsigned NREG  = 1 << ADDR_W;
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0]  starve_cnt, starve_cnt_nxt;
    logic [NREG-1:0]   pend, pend_nxt;
    logic              force_b_c;
    logic              a_ready_c, b_ready_c;
    logic              a_acc_c, b_acc_c;
    logic              wr_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [DATA_W-1:0] wr_data_c;
    logic              claim_err_nxt;

    // Grant: A by default, B once it has been stalled STARVE_LIMIT cycles
    always_comb begin
        force_b_c = (starve_cnt >= CNT_W'(STARVE_LIMIT));
        a_ready_c = ~(force_b_c & bus.b_valid);
        b_ready_c = ~bus.a_valid | force_b_c;
        a_acc_c   = bus.a_valid & a_ready_c;
        b_acc_c   = bus.b_valid & b_ready_c;
    end

    assign bus.a_ready = a_ready_c;
    assign bus.b_ready = b_ready_c;
    assign bus.hazard1 = pend[bus.raddr1];
    assign bus.hazard2 = pend[bus.raddr2];

    // Write mux; at most one side is accepted per cycle, r0 writes are swallowed
    always_comb begin
        wr_addr_c = bus.a_addr;
        wr_data_c = bus.a_data;
        if (b_acc_c) begin
            wr_addr_c = bus.b_addr;
            wr_data_c = bus.b_data;
        end
        wr_c = (a_acc_c | b_acc_c) & (wr_addr_c != '0);
    end

    always_comb begin
        starve_cnt_nxt = starve_cnt;
        if (b_acc_c || !bus.b_valid) begin
            starve_cnt_nxt = '0;
        end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
            starve_cnt_nxt = starve_cnt + CNT_W'(1);
        end
    end

    // Scoreboard: a new claim supersedes a same-cycle B retire of that register
    always_comb begin
        pend_nxt      = pend;
        claim_err_nxt = 1'b0;
        if (b_acc_c) begin
            pend_nxt[bus.b_addr] = 1'b0;
        end
        if (bus.claim_valid && (bus.claim_addr != '0)) begin
            pend_nxt[bus.claim_addr] = 1'b1;
            claim_err_nxt = pend[bus.claim_addr] &
                            ~(b_acc_c && (bus.b_addr == bus.claim_addr));
        end
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt    <= '0;
            pend          <= '0;
            bus.rf_we     <= 1'b0;
            bus.rf_waddr  <= '0;
            bus.rf_wdata  <= '0;
            bus.claim_err <= 1'b0;
        end else begin
            starve_cnt    <= starve_cnt_nxt;
            pend          <= pend_nxt;
            bus.rf_we     <= wr_c;
            bus.claim_err <= claim_err_nxt;
            if (wr_c) begin
                bus.rf_waddr <= wr_addr_c;
                bus.rf_wdata <= wr_data_c;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Table-driven bench for regfile_wr_arbiter with a write-port scoreboard queue.
module tb_regfile_wr_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wr_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic        av; logic [4:0] aa; logic [31:0] ad;
        logic        bv; logic [4:0] ba; logic [31:0] bd;
        logic        cv; logic [4:0] ca;
        logic [4:0]  r1; logic [4:0] r2;
        logic        ar; logic br; logic h1; logic h2; logic cerr;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        chk_ad;
        logic        cerr;
    } exp_t;

    vec_t        vt[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  last_addr;
    logic [31:0] last_data;

    function automatic vec_t mk(int unsigned av, int unsigned aa, int unsigned ad,
                                int unsigned bv, int unsigned ba, int unsigned bd,
                                int unsigned cv, int unsigned ca,
                                int unsigned r1, int unsigned r2,
                                int unsigned ar, int unsigned br,
                                int unsigned h1, int unsigned h2, int unsigned cerr);
        vec_t v;
        v.av = 1'(av); v.aa = 5'(aa); v.ad = 32'(ad);
        v.bv = 1'(bv); v.ba = 5'(ba); v.bd = 32'(bd);
        v.cv = 1'(cv); v.ca = 5'(ca);
        v.r1 = 5'(r1); v.r2 = 5'(r2);
        v.ar = 1'(ar); v.br = 1'(br); v.h1 = 1'(h1); v.h2 = 1'(h2); v.cerr = 1'(cerr);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.a_valid = v.av; bus.a_addr = v.aa; bus.a_data = v.ad;
        bus.b_valid = v.bv; bus.b_addr = v.ba; bus.b_data = v.bd;
        bus.claim_valid = v.cv; bus.claim_addr = v.ca;
        bus.raddr1 = v.r1; bus.raddr2 = v.r2;
    endtask

    // Drive one vector, check grant/hazards, predict the write port, compare after the edge
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        logic acc;
        logic [4:0] addr;
        logic [31:0] data;
        @(negedge clk);
        drive(v);
        #1;
        chk($sformatf("v%0d a_ready", idx), 32'(bus.a_ready), 32'(v.ar));
        chk($sformatf("v%0d b_ready", idx), 32'(bus.b_ready), 32'(v.br));
        chk($sformatf("v%0d hazard1", idx), 32'(bus.hazard1), 32'(v.h1));
        chk($sformatf("v%0d hazard2", idx), 32'(bus.hazard2), 32'(v.h2));
        acc  = (v.av & v.ar) | (v.bv & v.br);
        addr = (v.bv & v.br) ? v.ba : v.aa;
        data = (v.bv & v.br) ? v.bd : v.ad;
        e.we     = acc && (addr != 5'd0);
        e.chk_ad = !(acc && (addr == 5'd0));
        if (e.we) begin
            last_addr = addr;
            last_data = data;
        end
        e.addr = last_addr;
        e.data = last_data;
        e.cerr = v.cerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard_empty", idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d rf_we", idx), 32'(bus.rf_we), 32'(e.we));
            if (e.chk_ad) begin
                chk($sformatf("v%0d rf_waddr", idx), 32'(bus.rf_waddr), 32'(e.addr));
                chk($sformatf("v%0d rf_wdata", idx), bus.rf_wdata, e.data);
            end
            chk($sformatf("v%0d claim_err", idx), 32'(bus.claim_err), 32'(e.cerr));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with every request asserted
        rst_n = 1'b0;
        drive(mk(1, 4, 32'h11, 1, 6, 32'h22, 1, 9, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 9, 6, 0, 0, 0, 0, 0));
        #1;
        chk("reset rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset rf_waddr", 32'(bus.rf_waddr), 32'd0);
        chk("reset rf_wdata", bus.rf_wdata, 32'd0);
        chk("reset claim_err", 32'(bus.claim_err), 32'd0);
        chk("reset hazard1", 32'(bus.hazard1), 32'd0);
        chk("reset hazard2", 32'(bus.hazard2), 32'd0);
        last_addr = 5'd0;
        last_data = 32'd0;

        //           av aa ad            bv ba bd            cv ca r1 r2 ar br h1 h2 ce
        vt.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,         0, 0, 0, 0, 1, 0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0, 0, 0, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,         1, 9, 9, 0, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,         1, 9, 9, 0, 1, 1, 1, 0, 1));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0, 9, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,         1, 0, 9, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(1, 0, 32'h55,       0, 0, 0,         0, 0, 9, 0, 1, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0,            1, 9, 32'h1234,  0, 0, 9, 0, 1, 1, 1, 0, 0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0, 9, 7, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,         1, 7, 9, 7, 1, 1, 0, 0, 0));
        vt.push_back(mk(0, 0, 0,            1, 7, 32'h77,    1, 7, 9, 7, 1, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 0,            0, 0, 0,         0, 0, 9, 7, 1, 1, 0, 1, 0));
        for (int i = 0; i < 4; i++) begin
            vt.push_back(mk(1, 1, 32'hA000_0000 + 32'(i), 1, 2, 32'hB000_0000 + 32'(i),
                            0, 0, 2, 7, 1, 0, 0, 1, 0));
        end
        vt.push_back(mk(1, 1, 32'hA000_0004, 1, 2, 32'hB000_0004, 0, 0, 2, 7, 0, 1, 0, 1, 0));
        vt.push_back(mk(1, 1, 32'hA000_0005, 1, 2, 32'hB000_0005, 0, 0, 2, 7, 1, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0,             1, 2, 32'hB000_0006, 0, 0, 2, 7, 1, 1, 0, 1, 0));
        vt.push_back(mk(0, 0, 0,             0, 0, 0,            0, 0, 2, 7, 1, 1, 0, 1, 0));

        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i], i);
        end

        // Reset arriving one edge after a B accept
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 1, 3, 3, 7, 0, 0, 0, 0, 0));
        @(negedge clk);
        drive(mk(0, 0, 0, 1, 3, 32'hCAFE, 0, 0, 3, 7, 0, 0, 0, 0, 0));
        #1;
        chk("midrst hazard1 before", 32'(bus.hazard1), 32'd1);
        chk("midrst b_ready", 32'(bus.b_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("midrst rf_we inflight", 32'(bus.rf_we), 32'd1);
        chk("midrst rf_wdata inflight", bus.rf_wdata, 32'hCAFE);
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst rf_we", 32'(bus.rf_we), 32'd0);
        chk("midrst hazard1", 32'(bus.hazard1), 32'd0);
        chk("midrst hazard2", 32'(bus.hazard2), 32'd0);
        chk("midrst claim_err", 32'(bus.claim_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_addr = 5'd0;
        last_data = 32'd0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 3, 7, 1, 1, 0, 0, 0), 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
